// File: rtl/rs_sched_pkg.sv
// rs_sched_pkg: shared defaults and encoder helpers for the RS issue scheduler
package rs_sched_pkg;
  localparam int NUM_RS_DEF = 4;
  localparam int AGE_W_DEF = 2;
  localparam int AGE_MAX = (1 << AGE_W_DEF) - 1;
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) if (oh[i]) r |= 4'(i);
    return r;
  endfunction
  function automatic logic [15:0] lowest_set(input logic [15:0] v);
    return v & (~v + 16'd1);
  endfunction
endpackage

// File: rtl/rs_oldest_pick.sv
// rs_oldest_pick: oldest-ready selector with round-robin tie break from rr_ptr
module rs_oldest_pick import rs_sched_pkg::*; #(
  parameter int NUM_RS = NUM_RS_DEF,
  parameter int AGE_W = AGE_W_DEF,
  parameter int SEL_W = $clog2(NUM_RS)
) (
  input  logic [NUM_RS-1:0]            ready,
  input  logic [NUM_RS-1:0][AGE_W-1:0] age,
  input  logic [SEL_W-1:0]             rr_ptr,
  output logic [NUM_RS-1:0]            grant,
  output logic [SEL_W-1:0]             idx
);
  logic [AGE_W-1:0] max_age;
  logic [SEL_W-1:0] j;
  always_comb begin
    max_age = '0;
    j = '0;
    grant = '0;
    for (int i = 0; i < NUM_RS; i++) if (ready[i] && age[i] > max_age) max_age = age[i];
    // walk offsets downward so the candidate nearest rr_ptr is written last
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      j = rr_ptr + SEL_W'(i);
      if (ready[j] && age[j] == max_age) grant = NUM_RS'(1) << j;
    end
  end
  assign idx = SEL_W'(onehot_to_idx(16'(grant)));
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: allocates free RS entries and issues the oldest ready one
module rs_issue_scheduler import rs_sched_pkg::*; #(
  parameter int NUM_RS = NUM_RS_DEF,
  parameter int AGE_W = AGE_W_DEF,
  parameter int SEL_W = $clog2(NUM_RS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic [NUM_RS-1:0] rs_busy_i,
  input  logic [NUM_RS-1:0] rs_ready_i,
  input  logic              alloc_req_i,
  output logic [NUM_RS-1:0] alloc_grant_o,
  output logic              full_o,
  input  logic              stall_i,
  output logic              issue_valid_o,
  output logic [NUM_RS-1:0] issue_grant_o,
  output logic [SEL_W-1:0]  issue_sel_o,
  output logic [NUM_RS-1:0] rs_stall_o
);
  logic [NUM_RS-1:0][AGE_W-1:0] age;
  logic [SEL_W-1:0] rr_ptr, pick_idx;
  logic [NUM_RS-1:0] pick, free;
  logic fire;
  rs_oldest_pick #(.NUM_RS(NUM_RS), .AGE_W(AGE_W), .SEL_W(SEL_W)) u_pick (
    .ready(rs_ready_i), .age(age), .rr_ptr(rr_ptr), .grant(pick), .idx(pick_idx)
  );
  assign free = ~rs_busy_i;
  assign issue_valid_o = ~reset_i & |rs_ready_i;
  assign issue_grant_o = reset_i ? '0 : pick;
  assign issue_sel_o = reset_i ? '0 : pick_idx;
  assign rs_stall_o = ~issue_grant_o | {NUM_RS{stall_i}};
  assign fire = issue_valid_o & ~stall_i;
  assign full_o = ~reset_i & &rs_busy_i;
  assign alloc_grant_o = (reset_i | ~alloc_req_i) ? '0 : NUM_RS'(lowest_set(16'(free)));
  always_ff @(posedge clk_i)
    if (reset_i || flush_i) begin
      age <= '0;
      rr_ptr <= '0;
    end else begin
      for (int k = 0; k < NUM_RS; k++)
        age[k] <= (!rs_ready_i[k] || (fire && pick[k])) ? '0 : (&age[k] ? age[k] : age[k] + 1'b1);
      if (fire) rr_ptr <= pick_idx + 1'b1;
    end
  a_grant_onehot: assert property (@(posedge clk_i) $onehot0(issue_grant_o));
  a_grant_ready:  assert property (@(posedge clk_i) (issue_grant_o & ~rs_ready_i) == '0);
  a_alloc_free:   assert property (@(posedge clk_i) (alloc_grant_o & rs_busy_i) == '0);
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb_rs_issue_scheduler: scoreboard bench driven by a cycle model of the scheduler
module tb_rs_issue_scheduler;
  typedef struct packed {
    logic       valid;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] stall;
    logic [3:0] alloc;
    logic       full;
  } exp_t;
  logic clk_i = 0, reset_i = 1, flush_i = 0, alloc_req_i = 0, stall_i = 0;
  logic [3:0] rs_busy_i = '0, rs_ready_i = '0;
  logic [3:0] alloc_grant_o, issue_grant_o, rs_stall_o;
  logic full_o, issue_valid_o;
  logic [1:0] issue_sel_o;
  exp_t obs, e;
  exp_t sb[$];
  int m_age[4];
  int m_rr;
  int vectors = 0, miscompares = 0;
  always #5 clk_i = ~clk_i;
  rs_issue_scheduler dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .rs_busy_i(rs_busy_i),
    .rs_ready_i(rs_ready_i), .alloc_req_i(alloc_req_i), .alloc_grant_o(alloc_grant_o),
    .full_o(full_o), .stall_i(stall_i), .issue_valid_o(issue_valid_o),
    .issue_grant_o(issue_grant_o), .issue_sel_o(issue_sel_o), .rs_stall_o(rs_stall_o)
  );
  assign obs = {issue_valid_o, issue_grant_o, issue_sel_o, rs_stall_o, alloc_grant_o, full_o};
  function automatic exp_t model_eval();
    exp_t r;
    int best, mx;
    r = '0;
    best = -1;
    mx = -1;
    if (!reset_i) begin
      for (int k = 0; k < 4; k++) if (rs_ready_i[k] && m_age[k] > mx) mx = m_age[k];
      for (int off = 0; off < 4; off++) begin
        int j;
        j = (m_rr + off) % 4;
        if (best < 0 && rs_ready_i[j] && m_age[j] == mx) best = j;
      end
      r.valid = best >= 0;
      if (best >= 0) begin
        r.grant[best] = 1'b1;
        r.sel = 2'(best);
      end
      r.full = &rs_busy_i;
      if (alloc_req_i)
        for (int k = 3; k >= 0; k--) if (!rs_busy_i[k]) begin
          r.alloc = '0;
          r.alloc[k] = 1'b1;
        end
    end
    r.stall = ~r.grant | {4{stall_i}};
    return r;
  endfunction
  task automatic apply();
    sb.push_back(model_eval());
    @(negedge clk_i);
  endtask
  task automatic adv(input exp_t x);
    bit fire;
    @(posedge clk_i);
    fire = x.valid && !stall_i && !reset_i;
    if (reset_i || flush_i) begin
      for (int k = 0; k < 4; k++) m_age[k] = 0;
      m_rr = 0;
    end else begin
      for (int k = 0; k < 4; k++)
        m_age[k] = (!rs_ready_i[k] || (fire && x.grant[k])) ? 0 : (m_age[k] < 3 ? m_age[k] + 1 : 3);
      if (fire) m_rr = (int'(x.sel) + 1) % 4;
    end
    #1;
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      reset_i = c < 2;
      rs_ready_i = c < 2 ? 4'b1111 : 4'b0000;
      rs_busy_i = 4'b1111;
      alloc_req_i = 1;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h exp %h", c, obs, e);
      end
      adv(e);
    end
  endtask
  task automatic test_age_order();
    logic [3:0] rdy[4] = '{4'b0000, 4'b0100, 4'b0101, 4'b0001};
    logic [3:0] gnt[4] = '{4'b0000, 4'b0100, 4'b0100, 4'b0001};
    logic stl[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      rs_ready_i = rdy[c];
      stall_i = stl[c];
      alloc_req_i = 0;
      rs_busy_i = 4'b1111;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e || issue_grant_o !== gnt[c]) begin
        miscompares++;
        $display("FAIL age_order c%0d: got %h exp %h grant_exp %b", c, obs, e, gnt[c]);
      end
      adv(e);
    end
  endtask
  task automatic test_tie_rr();
    logic [3:0] prev;
    rs_ready_i = 0;
    flush_i = 1;
    apply();
    e = sb.pop_front();
    adv(e);
    flush_i = 0;
    prev = 0;
    for (int c = 0; c < 4; c++) begin
      rs_ready_i = 4'b1111 & ~prev;
      stall_i = 0;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e || issue_sel_o !== 2'(c)) begin
        miscompares++;
        $display("FAIL tie_rr c%0d: got %h exp %h sel_exp %0d", c, obs, e, c);
      end
      prev = e.grant;
      adv(e);
    end
  endtask
  task automatic test_stall_hold();
    rs_ready_i = 0;
    flush_i = 1;
    apply();
    e = sb.pop_front();
    adv(e);
    flush_i = 0;
    for (int c = 0; c < 7; c++) begin
      rs_ready_i = c < 6 ? 4'b0010 : 4'b0000;
      stall_i = c < 5;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e || (c == 5 && rs_stall_o !== 4'b1101) || (c < 5 && rs_stall_o !== 4'b1111)) begin
        miscompares++;
        $display("FAIL stall_hold c%0d: got %h exp %h", c, obs, e);
      end
      adv(e);
    end
  endtask
  task automatic test_alloc();
    logic [3:0] busy[5] = '{4'b1011, 4'b1111, 4'b1111, 4'b0000, 4'b0110};
    logic req[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    rs_ready_i = 0;
    stall_i = 0;
    for (int c = 0; c < 13; c++) begin
      rs_busy_i = c < 5 ? busy[c] : 4'($urandom);
      alloc_req_i = c < 5 ? req[c] : 1'($urandom);
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e || (c == 0 && alloc_grant_o !== 4'b0100)) begin
        miscompares++;
        $display("FAIL alloc c%0d: got %h exp %h", c, obs, e);
      end
      adv(e);
    end
  endtask
  task automatic test_flush();
    for (int c = 0; c < 7; c++) begin
      rs_ready_i = 4'b1111;
      rs_busy_i = 4'b1111;
      alloc_req_i = 0;
      stall_i = c < 4;
      flush_i = c == 4;
      reset_i = c == 6;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e || (c == 5 && issue_grant_o !== 4'b0001) || (c == 6 && (issue_valid_o !== 0 || rs_stall_o !== 4'b1111))) begin
        miscompares++;
        $display("FAIL flush c%0d: got %h exp %h", c, obs, e);
      end
      adv(e);
    end
    reset_i = 0;
    flush_i = 0;
  endtask
  task automatic test_simul();
    for (int c = 0; c < 2; c++) begin
      rs_ready_i = c == 0 ? 4'b1000 : 4'b0000;
      rs_busy_i = c == 0 ? 4'b1111 : 4'b0111;
      alloc_req_i = 1;
      stall_i = 0;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e || alloc_grant_o !== (c == 0 ? 4'b0000 : 4'b1000)) begin
        miscompares++;
        $display("FAIL simul c%0d: got %h exp %h", c, obs, e);
      end
      adv(e);
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 60; c++) begin
      rs_ready_i = 4'($urandom);
      rs_busy_i = 4'($urandom) | rs_ready_i;
      alloc_req_i = 1'($urandom);
      stall_i = $urandom_range(0, 3) == 0;
      flush_i = $urandom_range(0, 15) == 0;
      reset_i = $urandom_range(0, 31) == 0;
      apply();
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL random c%0d: got %h exp %h", c, obs, e);
      end
      adv(e);
    end
    reset_i = 0;
    flush_i = 0;
  endtask
  initial begin
    for (int k = 0; k < 4; k++) m_age[k] = 0;
    m_rr = 0;
    #1;
    test_reset();
    test_age_order();
    test_tie_rr();
    test_stall_hold();
    test_alloc();
    test_flush();
    test_simul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
